// File: rtl/sha256_compress64_if.sv
// sha256_compress64_if: handshake and data bundle between the schedule stage
// (master) and the SHA-256 compression block (slave).
interface sha256_compress64_if;
    logic           enable;
    logic           use_iv;
    logic [2047:0]  w_vector;
    logic [255:0]   prev_hash;
    logic           ready;
    logic           hash_complete;
    logic [255:0]   hash_out;

    modport master (
        output enable, use_iv, w_vector, prev_hash,
        input  ready, hash_complete, hash_out
    );

    modport slave (
        input  enable, use_iv, w_vector, prev_hash,
        output ready, hash_complete, hash_out
    );
endinterface

// File: rtl/sha256_compress64.sv
// sha256_compress64: iterative SHA-256 compression of one 2048-bit W vector,
// one round per clock, followed by the feed-forward addition.
// Build macro SHA256_COMPRESS_UNROLL2_EN computes two cascaded rounds per clock.
module sha256_compress64 #(
    parameter int ROUNDS = 64
) (
    input  logic               clock,
    input  logic               reset,
    sha256_compress64_if.slave bus
);
    localparam int CW = $clog2(ROUNDS);
`ifdef SHA256_COMPRESS_UNROLL2_EN
    localparam int STEP = 2;
`else
    localparam int STEP = 1;
`endif
    localparam logic [CW-1:0] LAST = CW'(ROUNDS - STEP);
    localparam logic [CW-1:0] INC  = CW'(STEP);

    localparam logic [255:0] IV = {
        32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
        32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19
    };

    localparam logic [31:0] K_ROM [ROUNDS] = '{
        32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
        32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
        32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
        32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
        32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
        32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
        32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
        32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
    };

    typedef enum logic [1:0] {
        IDLE,
        ROUND,
        FINAL
    } state_t;

    state_t          state;
    state_t          next_state;
    logic [CW-1:0]   counter;
    logic [255:0]    work;
    logic [255:0]    next_work;
    logic [255:0]    h_reg;
    logic [255:0]    chain;
    logic [255:0]    sum;
    logic [31:0]     w_mem [ROUNDS];

    function automatic logic [31:0] big_sigma0(input logic [31:0] x);
        return {x[1:0], x[31:2]} ^ {x[12:0], x[31:13]} ^ {x[21:0], x[31:22]};
    endfunction

    function automatic logic [31:0] big_sigma1(input logic [31:0] x);
        return {x[5:0], x[31:6]} ^ {x[10:0], x[31:11]} ^ {x[24:0], x[31:25]};
    endfunction

    // One SHA-256 round on the packed working state {a,b,c,d,e,f,g,h}.
    function automatic logic [255:0] round_step(input logic [255:0] s,
                                                input logic [31:0]  k,
                                                input logic [31:0]  w);
        logic [31:0] a, b, c, d, e, f, g, h, t1, t2;
        {a, b, c, d, e, f, g, h} = s;
        t1 = h + big_sigma1(e) + ((e & f) ^ (~e & g)) + k + w;
        t2 = big_sigma0(a) + ((a & b) ^ (a & c) ^ (b & c));
        return {t1 + t2, a, b, c, d + t1, e, f, g};
    endfunction

    // Chaining value selection between the standard IV and the previous block's hash.
    always_comb begin
        chain = bus.use_iv ? IV : bus.prev_hash;
    end

`ifdef SHA256_COMPRESS_UNROLL2_EN
    logic [CW-1:0] counter_odd;

    // Two cascaded rounds per clock; the counter is always even here.
    always_comb begin
        counter_odd = {counter[CW-1:1], 1'b1};
        next_work   = round_step(work, K_ROM[counter], w_mem[counter]);
        next_work   = round_step(next_work, K_ROM[counter_odd], w_mem[counter_odd]);
    end
`else
    // Single round per clock indexed by the round counter.
    always_comb begin
        next_work = round_step(work, K_ROM[counter], w_mem[counter]);
    end
`endif

    // Feed-forward: lane-wise addition of the latched chaining value and a..h.
    always_comb begin
        sum = '0;
        for (int i = 0; i < 8; i++) begin
            sum[32*i +: 32] = h_reg[32*i +: 32] + work[32*i +: 32];
        end
    end

    // State register.
    always_ff @(posedge clock) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state logic and the ready indication.
    always_comb begin
        next_state = state;
        bus.ready  = 1'b0;
        case (state)
            IDLE: begin
                bus.ready = 1'b1;
                if (bus.enable) begin
                    next_state = ROUND;
                end
            end
            ROUND: begin
                if (counter == LAST) begin
                    next_state = FINAL;
                end
            end
            FINAL: begin
                next_state = IDLE;
            end
            default: begin
                next_state = IDLE;
            end
        endcase
    end

    // Datapath: latch inputs on accept, iterate rounds, publish the digest.
    always_ff @(posedge clock) begin
        if (!reset) begin
            counter           <= '0;
            work              <= '0;
            h_reg             <= '0;
            bus.hash_out      <= '0;
            bus.hash_complete <= 1'b0;
            for (int i = 0; i < ROUNDS; i++) begin
                w_mem[i] <= '0;
            end
        end else begin
            bus.hash_complete <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.enable) begin
                        counter <= '0;
                        h_reg   <= chain;
                        work    <= chain;
                        for (int i = 0; i < ROUNDS; i++) begin
                            w_mem[i] <= bus.w_vector[2047 - 32*i -: 32];
                        end
                    end
                end
                ROUND: begin
                    work    <= next_work;
                    counter <= counter + INC;
                end
                FINAL: begin
                    bus.hash_out      <= sum;
                    bus.hash_complete <= 1'b1;
                end
                default: begin
                    counter <= '0;
                end
            endcase
        end
    end
endmodule

// File: doc/sha256_compress64.md
Name: sha256_compress64

Overview:
- Downstream stage of the 64-word message-schedule (W vector) block.
- Consumes the completed 2048-bit W vector and a 256-bit chaining value.
- Runs the 64 SHA-256 compression rounds iteratively, one round per clock, then applies the feed-forward addition.
- Presents the updated 256-bit intermediate hash with a one-cycle completion pulse.

Parameters:
- ROUNDS, 64, number of compression rounds. Only 64 is legal; kept for counter sizing ($clog2(ROUNDS) bits).

Ports:
- clock  input  1  system clock; all state updates on rising edge.
- reset  input  1  synchronous, active-low reset.
- enable  input  1  start request; driven by the schedule stage's w_vector_complete.
- use_iv  input  1  1: chaining value is the FIPS 180-4 initial hash; 0: use prev_hash.
- w_vector  input  2048  W[0..63]; W[t] = w_vector[2047-32t -: 32], so W[0] is the MSW.
- prev_hash  input  256  chaining value H0..H7; H0 = [255:224].
- ready  output  1  high in IDLE; the block accepts enable.
- hash_complete  output  1  one-cycle pulse; hash_out valid and updated.
- hash_out  output  256  H0..H7 after feed-forward; H0 = [255:224].

Behaviour:
- All arithmetic is 32-bit modulo 2^32.
- Sigma0, Sigma1, Ch and Maj are per FIPS 180-4.
- K[0..63] are held in an internal constant ROM.
- FSM states: IDLE, ROUND, FINAL.
- Reset (reset==0 at an edge, any state):
  - state=IDLE, round counter=0.
  - a..h=0, latched W and H registers=0.
  - hash_out=0, hash_complete=0, ready=1.
  - A reset mid-operation aborts the block with no partial output; hash_out stays 0 until the next full completion.
- IDLE:
  - ready=1.
  - On an edge with enable=1:
    - Latch w_vector.
    - Latch chaining value H: IV if use_iv=1, else prev_hash.
    - Load a..h from H; round counter=0.
    - Go to ROUND.
  - enable=0: stay in IDLE.
- ROUND:
  - ready=0.
  - Each edge performs round t=counter: T1=h+Sigma1(e)+Ch(e,f,g)+K[t]+W[t]; T2=Sigma0(a)+Maj(a,b,c).
  - Register shift: h=g, g=f, f=e, e=d+T1, d=c, c=b, b=a, a=T1+T2.
  - Counter increments.
  - At t=63: go to FINAL. Counter wraps to 0; no out-of-range W/K index is ever used.
- FINAL:
  - One edge: hash_out = {H0+a, …, H7+h}.
  - hash_complete=1 for exactly the following cycle.
  - Go to IDLE.
- Latency:
  - enable sampled at edge E.
  - Rounds occur on edges E+1..E+64.
  - hash_out is updated and hash_complete is high in the cycle after edge E+65.
  - Back-to-back: a new enable is accepted at edge E+66 (the same cycle hash_complete is high).
- enable while ready=0 is ignored: no queueing, no effect on the current computation.
- w_vector and prev_hash may change after the accept edge; the internal copies are used.
- hash_out holds its value until the next FINAL or a reset.

Optional Feature:
- Macro SHA256_COMPRESS_UNROLL2_EN.
- Defined:
  - Two cascaded rounds (t, t+1) are computed per ROUND edge; the counter steps by 2.
  - FINAL is entered after the edge computing rounds 62/63.
  - Rounds occur on edges E+1..E+32; hash_complete is high after edge E+33; the next accept is at E+34.
- Undefined: one round per edge as above.
- hash_out values are identical in both builds.

Test Plan:
- Reset behaviour:
  - Stimulus: hold reset=0 for 3 cycles with enable=1.
  - Required: ready=1, hash_complete=0, hash_out=0; no start on release until enable is sampled.
- Single block "abc":
  - Stimulus: W vector from the reference model, use_iv=1.
  - Required: hash_out=ba7816bf 8f01cfea 414140de 5dae2223 b00361a3 96177a9c b410ff61 f20015ad.
  - Required: hash_complete pulses exactly 65 cycles after the enable edge (33 with UNROLL2).
- Empty message:
  - Stimulus: padded single block, use_iv=1.
  - Required: hash_out=e3b0c442 98fc1c14 9afbf4c8 996fb924 27ae41e4 649b934c a495991b 7852b855.
- Two-block chaining:
  - Stimulus: 56-byte message "abcdbcdecdefdefgefghfghighijhijkijkljklmklmnlmnomnopnopq".
  - Block 1 with use_iv=1; block 2 with use_iv=0 and prev_hash=block-1 hash_out.
  - Required: final hash_out=248d6a61 d20638b8 e5c02693 0c3e6039 a33ce459 64ff2167 f6ecedd4 19db06c1.
- Busy and back-to-back:
  - Stimulus: pulse enable with corrupted w_vector at cycles 10 and 40 after the start.
  - Required: result unchanged.
  - Stimulus: assert enable in the hash_complete cycle.
  - Required: the second hash starts immediately and completes 65 cycles later.
- Reset mid-operation:
  - Stimulus: reset=0 at round 30, release, then restart "abc".
  - Required: no hash_complete from the aborted run; the correct "abc" digest after restart.
